// File: rtl/hight_sched.sv
// Round-robin scheduler sharing one hight core between two requesters.
// Sequences core load/run, counts the fixed core latency and returns the tagged result.
module hight_sched #(
    parameter int CORE_LAT = 35,
    parameter int LOAD_CYC = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [63:0]  req0_p,
    input  logic [63:0]  req1_p,
    input  logic [127:0] req0_mk,
    input  logic [127:0] req1_mk,
    input  logic         req0_ed,
    input  logic         req1_ed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_c,
    output logic         out_id,
    output logic         busy,
    output logic [63:0]  core_p,
    output logic [127:0] core_mk,
    output logic         core_ed,
    output logic         core_rst,
    input  logic [63:0]  core_c
);
    // Same counter times LOAD and RUN; LOAD_CYC is expected not to exceed CORE_LAT.
    localparam int CW = $clog2(CORE_LAT) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state;
    logic          rr;
    logic          grant;
    logic          fire;
    logic [CW-1:0] cnt;

    // Tie goes to the rr pointer; otherwise the sole valid requester wins.
    assign grant      = (req0_valid & req1_valid) ? rr : req1_valid;
    assign req0_ready = (state == IDLE) & req0_valid & ~grant;
    assign req1_ready = (state == IDLE) & req1_valid & grant;
    assign fire       = req0_ready | req1_ready;
    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rr       <= 1'b0;
            cnt      <= '0;
            out_c    <= '0;
            out_id   <= 1'b0;
            core_p   <= '0;
            core_mk  <= '0;
            core_ed  <= 1'b0;
            core_rst <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    core_rst <= 1'b1;
                    if (fire) begin
                        core_p  <= grant ? req1_p  : req0_p;
                        core_mk <= grant ? req1_mk : req0_mk;
                        core_ed <= grant ? req1_ed : req0_ed;
                        out_id  <= grant;
                        rr      <= ~grant;
                        cnt     <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt == CW'(LOAD_CYC - 1)) begin
                        cnt      <= '0;
                        core_rst <= 1'b0;
                        state    <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    // This edge is the CORE_LAT-th one the core sees out of reset.
                    if (cnt == CW'(CORE_LAT - 1)) begin
                        out_c    <= core_c;
                        cnt      <= '0;
                        core_rst <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hight_sched.sv
// Bench for hight_sched: latency-exact core stand-in, table vectors, scoreboard queue,
// hand sequences for tie, backpressure, mid-job reset, plus an enc/dec round-trip sweep.
module tb_hight_sched;
    localparam int CORE_LAT = 35;
    localparam int LOAD_CYC = 1;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [63:0]  req0_p, req1_p;
    logic [127:0] req0_mk, req1_mk;
    logic         req0_ed, req1_ed;
    logic         out_valid, out_ready;
    logic [63:0]  out_c;
    logic         out_id;
    logic         busy;
    logic [63:0]  core_p;
    logic [127:0] core_mk;
    logic         core_ed, core_rst;
    logic [63:0]  core_c;

    hight_sched #(.CORE_LAT(CORE_LAT), .LOAD_CYC(LOAD_CYC)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_p(req0_p), .req1_p(req1_p),
        .req0_mk(req0_mk), .req1_mk(req1_mk),
        .req0_ed(req0_ed), .req1_ed(req1_ed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_id(out_id), .busy(busy),
        .core_p(core_p), .core_mk(core_mk), .core_ed(core_ed),
        .core_rst(core_rst), .core_c(core_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invertible stand-in cipher: ed=1 encrypts, ed=0 decrypts.
    function automatic logic [63:0] toy(input logic [63:0] p, input logic [127:0] mk, input logic ed);
        logic [63:0] x;
        if (ed) begin
            x = p ^ mk[63:0];
            x = {x[50:0], x[63:51]};
            return x + mk[127:64];
        end else begin
            x = p - mk[127:64];
            x = {x[12:0], x[63:13]};
            return x ^ mk[63:0];
        end
    endfunction

    // Core stand-in: the result is present only after exactly CORE_LAT-1 edges out of reset,
    // so a capture one edge early or late reads a poison value.
    logic [7:0] mcnt;
    always @(posedge clk) begin
        if (core_rst) mcnt <= 8'd0;
        else if (mcnt != 8'hff) mcnt <= mcnt + 8'd1;
    end
    assign core_c = (mcnt == 8'(CORE_LAT - 1)) ? toy(core_p, core_mk, core_ed)
                                               : {56'hBAD000_0000_0000, mcnt};

    typedef struct {
        logic [63:0] c;
        logic        id;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic         id;
        logic [63:0]  p;
        logic [127:0] mk;
        logic         ed;
        int           bp;
        logic [63:0]  exp_c;
    } vec_t;
    vec_t tbl[6];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop();
        exp_t e;
        if (q.size() == 0) begin
            chk("sb_unexpected_out", 0, 1);
        end else begin
            e = q.pop_front();
            chk("out_c", out_c, e.c);
            chk("out_id", out_id, e.id);
        end
    endtask

    // Raise one request, wait for its acceptance, push the expected result, then scramble inputs.
    task automatic start_req(input logic id, input logic [63:0] p, input logic [127:0] mk,
                             input logic ed, input logic [63:0] exp);
        exp_t e;
        bit found = 0;
        if (id) begin req1_p = p; req1_mk = mk; req1_ed = ed; req1_valid = 1'b1; end
        else    begin req0_p = p; req0_mk = mk; req0_ed = ed; req0_valid = 1'b1; end
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            found = id ? req1_ready : req0_ready;
        end
        chk("fire", found, 1);
        if (found) begin
            e.c = exp; e.id = id;
            q.push_back(e);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_p = {$urandom, $urandom}; req0_mk = {$urandom, $urandom, $urandom, $urandom};
        req1_p = {$urandom, $urandom}; req1_mk = {$urandom, $urandom, $urandom, $urandom};
        req0_ed = ~req0_ed; req1_ed = ~req1_ed;
    endtask

    // Called just after the fire edge: checks load/run timing, input hold and the result handshake.
    task automatic finish_job(input logic [63:0] p, input logic [127:0] mk, input int bp,
                              output logic [63:0] c);
        int  hi = 0, lo = 0;
        bit  hold_ok = 1, busy_ok = 1, seen = 0;
        logic id0;
        c = '0;
        if (bp > 0) out_ready = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            else begin
                if (core_rst) hi++;
                else begin
                    lo++;
                    if (core_p !== p || core_mk !== mk) hold_ok = 0;
                end
                if (!busy || req0_ready || req1_ready) busy_ok = 0;
            end
        end
        chk("latency", hi + lo, LOAD_CYC + CORE_LAT);
        chk("core_rst_high", hi, LOAD_CYC);
        chk("core_rst_low", lo, CORE_LAT);
        chk("core_in_hold", hold_ok, 1);
        chk("busy_no_ready", busy_ok, 1);
        if (!seen) begin
            out_ready = 1'b1;
            return;
        end
        c = out_c; id0 = out_id;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, busy, req0_ready, req1_ready, out_id, out_c},
                           {1'b1, 1'b1, 1'b0, 1'b0, id0, c});
        end
        out_ready = 1'b1;
        sb_pop();
        @(posedge clk); #1;
        chk("out_done", {out_valid, busy}, 2'b00);
    endtask

    logic [63:0]  c, pe;
    logic [127:0] mke;
    int           w;

    initial begin
        reset = 1'b0; out_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_p = '0; req1_p = '0; req0_mk = '0; req1_mk = '0; req0_ed = 1'b0; req1_ed = 1'b0;

        tbl[0] = '{1'b0, 64'h0, 128'h00112233445566778899aabbccddeeff, 1'b1, 0, 64'h0};
        tbl[1] = '{1'b1, 64'hffff_ffff_ffff_ffff, 128'h0, 1'b1, 0, 64'h0};
        tbl[2] = '{1'b0, 64'h0123_4567_89ab_cdef, 128'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978, 1'b1, 20, 64'h0};
        tbl[3] = '{1'b1, 64'hdead_beef_cafe_f00d, 128'h1, 1'b0, 3, 64'h0};
        tbl[4] = '{1'b1, 64'h8000_0000_0000_0001, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 1'b0, 0, 64'h0};
        tbl[5] = '{1'b0, 64'h5555_aaaa_5555_aaaa, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b1, 1, 64'h0};
        foreach (tbl[i]) tbl[i].exp_c = toy(tbl[i].p, tbl[i].mk, tbl[i].ed);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {req0_ready, req1_ready, out_valid, busy, core_rst, out_id, core_ed}, 7'b0000100);
        chk("rst_out_c", out_c, 0);
        chk("rst_core_p", core_p, 0);
        chk("rst_core_mk", core_mk, 0);

        // Tie from reset: strict alternation 0,1,0, first acceptance in the first cycle out of reset
        @(posedge clk); #1;
        reset = 1'b1;
        req0_p = 64'h1111_2222_3333_4444; req0_mk = 128'hA5A5; req0_ed = 1'b1;
        req1_p = 64'h9999_8888_7777_6666; req1_mk = 128'h5A5A_0000_0000_0000_0000_0000_0000_0001; req1_ed = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            exp_t e;
            w = 0;
            while (w < 100) begin
                @(negedge clk);
                if (req0_ready | req1_ready) break;
                w++;
            end
            if (j == 0) chk("tie_first_cycle", w, 0);
            chk("tie_order", {req1_ready, req0_ready}, (j == 1) ? 2'b10 : 2'b01);
            e.id = (j == 1);
            e.c  = (j == 1) ? toy(req1_p, req1_mk, 1'b1) : toy(req0_p, req0_mk, 1'b1);
            q.push_back(e);
            pe  = (j == 1) ? req1_p : req0_p;
            mke = (j == 1) ? req1_mk : req0_mk;
            @(posedge clk); #1;
            if (j == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            finish_job(pe, mke, 0, c);
        end

        // Table vectors, including the known-key job and backpressure cases
        for (int i = 0; i < 6; i++) begin
            start_req(tbl[i].id, tbl[i].p, tbl[i].mk, tbl[i].ed, tbl[i].exp_c);
            finish_job(tbl[i].p, tbl[i].mk, tbl[i].bp, c);
        end

        // Mid-job reset at RUN counter 10, then a req1 job
        start_req(1'b0, 64'h7777, 128'h3333, 1'b1, toy(64'h7777, 128'h3333, 1'b1));
        repeat (11) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst_ctrl", {req0_ready, req1_ready, out_valid, busy, core_rst, out_id, core_ed}, 7'b0000100);
        chk("midrst_out_c", out_c, 0);
        chk("midrst_core", {core_p, core_mk}, 0);
        q.delete();
        w = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) w++;
        end
        chk("midrst_no_out", w, 0);
        @(posedge clk); #1;
        start_req(1'b1, 64'h0bad_c0de, 128'h1234, 1'b1, toy(64'h0bad_c0de, 128'h1234, 1'b1));
        finish_job(64'h0bad_c0de, 128'h1234, 0, c);

        // Round-trip sweep: even jobs encrypt on req0, odd jobs decrypt the DUT result on req1
        for (int i = 0; i < 241; i++) begin
            logic [63:0] p;
            logic [127:0] mk;
            if (i % 2 == 0) begin
                p  = {$urandom, $urandom};
                mk = {$urandom, $urandom, $urandom, $urandom};
                pe = p; mke = mk;
                start_req(1'b0, p, mk, 1'b1, toy(p, mk, 1'b1));
                finish_job(p, mk, 0, c);
            end else begin
                start_req(1'b1, c, mke, 1'b0, pe);
                finish_job(c, mke, 0, c);
            end
        end

        chk("sb_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
